// File: rtl/vegeta_act_feeder_pkg.sv
// vegeta_act_feeder_pkg: shared constants, gemm/PE mode encodings and feeder state enum
package vegeta_act_feeder_pkg;
  localparam int MUL_DATAWIDTH = 8;
  localparam int M = 2;
  localparam int BETA = 1;
  typedef enum logic [1:0] {
    DENSE = 2'b00,
    SP24  = 2'b01,
    SP14  = 2'b10
  } gemm_mode_e;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_e;
endpackage

// File: rtl/vegeta_act_feeder_fifo.sv
// act_feeder_fifo: registered-output-free circular FIFO, no bypass, occupancy counter
module act_feeder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q == AW'(DEPTH-1) ? '0 : wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q == AW'(DEPTH-1) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/vegeta_act_feeder.sv
// vegeta_act_feeder: buffers activation words and feeds them row-skewed into the PE array.
// Define VEGETA_ACT_FEEDER_PERF_EN to add the stall_cnt output.
module vegeta_act_feeder
  import vegeta_act_feeder_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int DEPTH = 4,
  parameter int W     = MUL_DATAWIDTH * M * BETA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_gemm_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROWS*W-1:0] in_data,
  input  logic              in_last,
  input  logic              out_ready,
  output logic [ROWS*W-1:0] act_out,
  output logic [1:0]        act_mode,
  output logic [1:0]        gemm_mode_out,
  output logic              busy,
  output logic              done
`ifdef VEGETA_ACT_FEEDER_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int DW = ROWS * W;
  localparam int CW = $clog2(ROWS + 1);
  feeder_state_e state_q;
  logic [DW:0] head;
  logic [DW-1:0] src;
  logic full, empty, push, pop, step;
  logic [1:0] act_mode_q, gemm_q;
  logic [CW-1:0] drain_q;
  assign in_ready = !rst && !full && (state_q == IDLE || state_q == STREAM);
  assign push     = in_valid && in_ready;
  assign step     = out_ready && ((state_q == STREAM && !empty) || state_q == DRAIN);
  assign pop      = step && state_q == STREAM;
  assign src      = state_q == DRAIN ? '0 : head[DW-1:0];
  act_feeder_fifo #(.WIDTH(DW + 1), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .din_i  ({in_last, in_data}),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty)
  );
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [W-1:0] row_q;
    if (r == 0) begin : g_direct
      always_ff @(posedge clk)
        if (rst) row_q <= '0;
        else if (step) row_q <= src[W-1:0];
    end else begin : g_skew
      logic [W-1:0] sk_q [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < r; k++) sk_q[k] <= '0;
          row_q <= '0;
        end else if (step) begin
          sk_q[0] <= src[r*W +: W];
          for (int k = 1; k < r; k++) sk_q[k] <= sk_q[k-1];
          row_q <= sk_q[r-1];
        end
      end
    end
    assign act_out[r*W +: W] = row_q;
  end
  // DRAIN runs ROWS-1 zero-injecting steps so the deepest skew row empties out
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      drain_q    <= '0;
      act_mode_q <= MODE_HOLD;
      gemm_q     <= 2'b00;
    end else begin
      act_mode_q <= step ? MODE_SHIFT : MODE_HOLD;
      case (state_q)
        IDLE:
          if (push) begin
            state_q <= STREAM;
            gemm_q  <= cfg_gemm_mode;
          end
        STREAM:
          if (pop && head[DW]) begin
            state_q <= ROWS == 1 ? DONE : DRAIN;
            drain_q <= '0;
          end
        DRAIN:
          if (step) begin
            if (drain_q == CW'(ROWS - 2)) state_q <= DONE;
            drain_q <= drain_q + 1'b1;
          end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign act_mode      = act_mode_q;
  assign gemm_mode_out = gemm_q;
  assign busy          = state_q != IDLE;
  assign done          = state_q == DONE;
`ifdef VEGETA_ACT_FEEDER_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk)
    if (rst) stall_q <= '0;
    else if (state_q == IDLE && push) stall_q <= '0;
    else if (state_q == STREAM && out_ready && empty && stall_q != '1) stall_q <= stall_q + 1'b1;
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_vegeta_act_feeder.sv
// tb_vegeta_act_feeder: scoreboard bench; stimulus queues expected skewed vectors, monitor pops on every shift.
module tb_vegeta_act_feeder;
  import vegeta_act_feeder_pkg::*;
  localparam int ROWS = 4;
  localparam int DEPTH = 4;
  localparam int W = MUL_DATAWIDTH * M * BETA;
  localparam int DW = ROWS * W;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_last, out_ready, busy, done;
  logic [1:0] cfg_gemm_mode, act_mode, gemm_mode_out;
  logic [DW-1:0] in_data, act_out;
`ifdef VEGETA_ACT_FEEDER_PERF_EN
  logic [31:0] stall_cnt;
`endif
  vegeta_act_feeder #(.ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_gemm_mode(cfg_gemm_mode),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_ready    (out_ready),
    .act_out      (act_out),
    .act_mode     (act_mode),
    .gemm_mode_out(gemm_mode_out),
    .busy         (busy),
    .done         (done)
`ifdef VEGETA_ACT_FEEDER_PERF_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_exp = '0;
  logic [DW-1:0] words[8];
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  always @(negedge clk)
    if (act_mode == MODE_SHIFT) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_shift actual=%h required=none", act_out);
      end else begin
        last_exp = exp_q.pop_front();
        chk("act_out", act_out, last_exp);
      end
    end
  task automatic expect_tile(input int n);
    logic [DW-1:0] v;
    for (int s = 0; s < n + ROWS - 1; s++) begin
      v = '0;
      for (int r = 0; r < ROWS; r++)
        if (s - r >= 0 && s - r < n) v[r*W +: W] = words[s-r][r*W +: W];
      exp_q.push_back(v);
    end
  endtask
  task automatic send(input logic [DW-1:0] d, input logic l);
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_timeout", 1, 0);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        @(posedge clk);
        #1 chk("done_pulse_len", done, 0);
        chk("idle_after_done", busy, 0);
        return;
      end
    end
    chk("done_timeout", 1, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b0; cfg_gemm_mode = DENSE;
    repeat (2) @(posedge clk);
    #1 chk("rst_act_out", act_out, 0);
    chk("rst_act_mode", act_mode, 0);
    chk("rst_gemm", gemm_mode_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("in_ready_after_rst", in_ready, 1);
    // single word walks down the skew one row per cycle
    words[0] = 64'hA3A3_A2A2_A1A1_A0A0;
    expect_tile(1);
    out_ready = 1'b1;
    send(words[0], 1'b1);
    chk("busy_stream", busy, 1);
    for (int c = 0; c < ROWS; c++) begin
      @(posedge clk);
      #1 chk("row_timing", act_out[c*W +: W], words[0][c*W +: W]);
    end
    chk("done_at_drain_end", done, 1);
    @(posedge clk);
    #1 chk("done_one_cycle", done, 0);
    chk("idle_after_t1", busy, 0);
    // backpressure mid-stream freezes outputs
    words[0] = 64'h1303_1202_1101_1000;
    words[1] = 64'h2313_2212_2111_2010;
    words[2] = 64'h3323_3222_3121_3020;
    expect_tile(3);
    send(words[0], 1'b0);
    send(words[1], 1'b0);
    send(words[2], 1'b1);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 chk("bp_mode_hold", act_mode, MODE_HOLD);
      chk("bp_frozen", act_out, last_exp);
    end
    out_ready = 1'b1;
    wait_done();
    chk("sb_empty_bp", exp_q.size(), 0);
    // FIFO full under backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) words[i] = {4{8'h40 + 8'(i), 8'h00 + 8'(i)}} ^ {16'h0300, 16'h0200, 16'h0100, 16'h0000};
    expect_tile(5);
    for (int i = 0; i < 4; i++) send(words[i], 1'b0);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk);
    #1 chk("full_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_step", in_ready, 1);
    send(words[4], 1'b1);
    wait_done();
    chk("sb_empty_full", exp_q.size(), 0);
    // gemm mode latched at tile start only
    cfg_gemm_mode = SP24;
    words[0] = 64'h5555_6666_7777_8888;
    words[1] = 64'h9999_AAAA_BBBB_CCCC;
    expect_tile(2);
    send(words[0], 1'b0);
    cfg_gemm_mode = SP14;
    chk("mode_latched", gemm_mode_out, SP24);
    send(words[1], 1'b1);
    chk("mode_ignored", gemm_mode_out, SP24);
    wait_done();
    chk("mode_kept_idle", gemm_mode_out, SP24);
    words[0] = 64'hDEAD_BEEF_CAFE_F00D;
    expect_tile(1);
    send(words[0], 1'b1);
    chk("mode_next_tile", gemm_mode_out, SP14);
    wait_done();
    // reset in the middle of DRAIN
    cfg_gemm_mode = SP24;
    words[0] = 64'h0F0F_0E0E_0D0D_0C0C;
    expect_tile(1);
    send(words[0], 1'b1);
    repeat (2) @(posedge clk);
    #1 chk("busy_drain", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 exp_q.delete();
    chk("mrst_act_out", act_out, 0);
    chk("mrst_act_mode", act_mode, 0);
    chk("mrst_gemm", gemm_mode_out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("mrst_ready_after", in_ready, 1);
    words[0] = 64'h7100_7200_7300_7400;
    words[1] = 64'h8100_8200_8300_8400;
    expect_tile(2);
    send(words[0], 1'b0);
    send(words[1], 1'b1);
    wait_done();
    chk("sb_empty_mrst", exp_q.size(), 0);
`ifdef VEGETA_ACT_FEEDER_PERF_EN
    words[0] = 64'h1111_2222_3333_4444;
    words[1] = 64'h5555_6666_7777_0000;
    expect_tile(2);
    send(words[0], 1'b0);
    chk("stall_cleared", stall_cnt, 0);
    repeat (3) @(posedge clk);
    #1 chk("stall_cnt", stall_cnt, 2);
    send(words[1], 1'b1);
    wait_done();
`endif
    repeat (3) @(posedge clk);
    #1 chk("sb_empty_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vegeta_act_feeder.md
VEGETA_ACT_FEEDER -- requirements
Module: vegeta_act_feeder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ROWS, 4: PE rows driven by the feeder.
- DEPTH, 4: input FIFO entries, power of two.
- W, MUL_DATAWIDTH*M*BETA: bits per row slice, from package constants.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: single clock.
- rst, in, 1: synchronous active-high reset.
- cfg_gemm_mode, in, 2: sparsity mode request (dense, 2:4, 1:4).
- in_valid, in, 1: upstream word valid.
- in_ready, out, 1: feeder accepts word.
- in_data, in, ROWS*W: one activation vector, row r at [r*W +: W].
- in_last, in, 1: marks final word of tile.
- out_ready, in, 1: array may advance this cycle.
- act_out, out, ROWS*W: skewed row slices, row r at [r*W +: W].
- act_mode, out, 2: 2'b10 = shift, 2'b00 = hold, to every row's mode input.
- gemm_mode_out, out, 2: latched tile sparsity mode.
- busy, out, 1: state is not IDLE.
- done, out, 1: one-cycle tile-complete pulse.

Function
REQ-003 The FSM SHALL have states IDLE, STREAM, DRAIN and DONE.
REQ-004 An input word SHALL be accepted when in_valid && in_ready; in_ready = !fifo_full && (state==IDLE || state==STREAM).
REQ-005 IDLE->STREAM SHALL occur on the first accepted word, with cfg_gemm_mode latched into gemm_mode_out on the same edge.
REQ-006 A cfg_gemm_mode change outside IDLE SHALL be ignored.
REQ-007 A word accepted at edge t SHALL be poppable from cycle t+1, i.e. no FIFO bypass.
REQ-008 step = out_ready && ((STREAM && !fifo_empty) || DRAIN).
REQ-009 act_mode SHALL be registered: it is 2'b10 in the cycle following a step and 2'b00 otherwise.
REQ-010 On step, row 0 SHALL load the FIFO head slice 0.
REQ-011 On step, row r>0 SHALL load slice r of the word popped r steps earlier, using an r-deep per-row skew shift register.
REQ-012 In DRAIN, zeros SHALL be injected in place of the FIFO head.
REQ-013 The skew registers SHALL hold when step is 0, including on an empty FIFO in STREAM and on out_ready low.
REQ-014 The in_last flag SHALL be stored per FIFO entry.
REQ-015 STREAM->DRAIN SHALL occur on the step that pops the last-flagged entry.
REQ-016 DRAIN SHALL perform exactly ROWS-1 steps, then go to DONE.
REQ-017 If ROWS==1, STREAM SHALL go directly to DONE.
REQ-018 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-019 A word accepted in IDLE in the same cycle as done SHALL NOT occur, since in_ready is 0 in DONE.
REQ-020 A simultaneous push and pop SHALL leave the occupancy unchanged; the pointers wrap modulo DEPTH.
REQ-021 Pushing when full or popping when empty SHALL be impossible by construction.

Reset
REQ-022 On rst, all of the following SHALL take effect, including mid-tile:
- state = IDLE.
- FIFO pointers and occupancy cleared.
- skew registers and act_out = 0.
- act_mode = 2'b00, gemm_mode_out = 2'b00, busy = 0, done = 0.
REQ-023 in_ready SHALL be 0 during rst and 1 in the cycle after reset releases.

Configuration
REQ-024 With VEGETA_ACT_FEEDER_PERF_EN defined, a 32-bit output stall_cnt SHALL count cycles in STREAM with out_ready && fifo_empty. It saturates at all-ones, is cleared by rst and on IDLE->STREAM.
REQ-025 Without VEGETA_ACT_FEEDER_PERF_EN, the stall_cnt port and its logic SHALL be absent.

Structure
REQ-026 The shared package SHALL hold MUL_DATAWIDTH, M, BETA, a gemm-mode enum (DENSE=2'b00, SP24=2'b01, SP14=2'b10), PE mode constants (MODE_SHIFT=2'b10, MODE_HOLD=2'b00) and the feeder state enum.
REQ-027 The FIFO SHALL be a sub-module, act_feeder_fifo, parameterised on width (ROWS*W+1) and DEPTH.

Verification
REQ-028 Single word: ROWS=4, out_ready=1, in_data slices {A0,A1,A2,A3} with last. Rows 0..3 SHALL show A0..A3 on consecutive cycles 1..4 after acceptance, and done SHALL pulse after 3 drain steps.
REQ-029 Backpressure: hold out_ready=0 for 3 cycles mid-STREAM. act_out and act_mode (00) SHALL be frozen, and no data SHALL be lost or duplicated.
REQ-030 FIFO full: DEPTH=4 with out_ready=0 and 5 offered words. in_ready SHALL drop after the 4th word, and the 5th word SHALL be accepted on the first step.
REQ-031 Mode latch: cfg_gemm_mode=01 at start, changed to 10 mid-tile. gemm_mode_out SHALL stay 01 until the next tile.
REQ-032 Reset mid-DRAIN: all outputs SHALL be zero next cycle, state IDLE, and a new tile SHALL run correctly.
REQ-033 With PERF_EN: 2 empty-FIFO cycles under out_ready=1 SHALL give stall_cnt=2.
